mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares the one 128×32 RAM between the instruction-fetch stage and the data-memory stage of the pipelined MIPS core. Each requester uses a req/ack handshake; the arbiter picks one request, drives the RAM port for one access cycle, and returns read data with a one-cycle ack. It sits between the pipeline's IF/MEM stages and the RAM's address/data/wre pins.

## Interface
- `ADDR_W`, 7, word-address width (128 words)
- `DATA_W`, 32, data width

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request (read only)
- `if_addr`  in  ADDR_W  fetch word address
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction, held until next fetch ack
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  DATA_W  load data, held until next data ack
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data (top level resolves the RAM's bidirectional bus)
- `mem_rdata`  in  DATA_W  RAM read data (combinational from `mem_addr`)
- `mem_wre`  out  1  RAM write enable, active-low: 0 = write, 1 = read
- `busy`  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick winner, latch its addr/we/wdata and grant id, go to ACCESS; else stay.
- ACCESS: drive `mem_addr`/`mem_wdata` from latch; `mem_wre` = 0 only if latched we = 1 (data store); capture `mem_rdata` into the winner's rdata register at cycle end (loads and fetches only; a store leaves `d_rdata` unchanged); go to RESP.
- RESP: pulse the winner's ack; `mem_wre` = 1; go to IDLE.
- Requester rule: hold req/addr/we/wdata stable from assertion through the ack cycle; drop req the cycle after ack or it is taken as a new request.
- Arbitration when both requests are present in IDLE: data wins (fixed priority, see Configuration). The loser keeps its req high and is granted on the next IDLE.
- Fetch never writes; `mem_wre` is 1 for every fetch grant.
- Addresses are used unmodified, with no wrap or bounds logic (ADDR_W covers the whole RAM).
- Outside ACCESS, `mem_wre` = 1 and `mem_addr`/`mem_wdata` hold their last value.

## Timing
- Request seen in IDLE at cycle N; RAM access at N+1; ack and rdata valid at N+2; next grant earliest at N+3. Peak throughput is 1 access per 3 cycles.
- Reset values: state IDLE; `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wre`=1, `busy`=0; round-robin pointer → fetch next.
- Reset asserted in ACCESS or RESP: return to IDLE, issue no ack for the aborted access, and force `mem_wre`=1 from the next edge. A store aborted in ACCESS has already been written.
- Requests present during reset are ignored; arbitration starts in the first cycle after reset deasserts.
- Ack outputs are registered and never high in two consecutive cycles.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the requester not granted last. The pointer updates on every grant, so with both requests held high, grants alternate fetch/data.
- Undefined: fixed priority, data over fetch. Fetch can be starved while data requests are continuous. No pointer register is built.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ACCESS/RESP), grant-id constants (GNT_IF, GNT_D), default ADDR_W/DATA_W.
- Sub-module `mem_arb_pick`: combinational winner selection from `if_req`, `d_req` and the pointer, containing the macro-dependent logic. FSM and datapath registers live in `mem_arbiter`.

## Test plan
- Lone fetch: `if_req`=1, `if_addr`=1, RAM[1]=0x214A000A → `mem_addr`=1 with `mem_wre`=1 at N+1; `if_ack`=1 and `if_rdata`=0x214A000A at N+2; `d_ack` stays 0.
- Store then load: `d_we`=1, addr 0x10, data 0xDEADBEEF → `mem_wre`=0 for exactly one cycle, `d_ack` at N+2; then a load from 0x10 → `d_rdata`=0xDEADBEEF.
- Simultaneous requests, macro off: `if_req`=`d_req`=1 held → data acked first at N+2, fetch acked at N+5.
- Simultaneous requests, macro on, both held 4 grants → grant order fetch, data, fetch, data; acks at N+2, N+5, N+8, N+11.
- Reset during the ACCESS of a load → no ack, `busy`=0 and `mem_wre`=1 the cycle after, `d_rdata` = 0.
- Req held after ack: `d_req` stays 1 through N+3 → second access acked at N+5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the IF/MEM memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 7;
  localparam int MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef logic gnt_t;

  localparam gnt_t GNT_IF = 1'b0;
  localparam gnt_t GNT_D  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick : combinational winner selection between fetch and data ports
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  gnt_t ptr,
`endif
  output logic any_req,
  output gnt_t gnt
);

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr names the requester preferred on a tie (the one not granted last)
  always_comb begin
    if (if_req && d_req) begin
      gnt = ptr;
    end else if (d_req) begin
      gnt = GNT_D;
    end else begin
      gnt = GNT_IF;
    end
  end
`else
  assign gnt = d_req ? GNT_D : GNT_IF;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : shares one single-port RAM between IF and MEM pipeline stages
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wre,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wre_q, mem_wre_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              w_any_req;
  gnt_t              w_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  gnt_t ptr_q, ptr_d;

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .ptr     (ptr_q),
    .any_req (w_any_req),
    .gnt     (w_win)
  );
`else
  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .any_req (w_any_req),
    .gnt     (w_win)
  );
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wre_d   = 1'b1;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = w_any_req;
        if (w_any_req) begin
          state_d = ST_ACCESS;
          gnt_d   = w_win;
          // The RAM-facing registers double as the request latch
          if (w_win == GNT_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wre_d   = ~d_we;
          end else begin
            mem_addr_d  = if_addr;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d = (w_win == GNT_IF) ? GNT_D : GNT_IF;
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (mem_wre_q) begin
          if (gnt_q == GNT_D) d_rdata_d  = mem_rdata;
          else                if_rdata_d = mem_rdata;
        end
        if_ack_d = (gnt_q == GNT_IF);
        d_ack_d  = (gnt_q == GNT_D);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wre_q   <= 1'b1;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q       <= GNT_IF;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wre_q   <= mem_wre_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wre   = mem_wre_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter with RAM model
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [6:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [6:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wre;
  logic        busy;

  logic [31:0] ram [0:127];
  logic        tb_we;
  logic [6:0]  tb_waddr;
  logic [31:0] tb_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tb_we)         ram[tb_waddr] <= tb_wdata;
    else if (!mem_wre) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  mem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_wre   (mem_wre),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] v);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
    tick;
    tb_we = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    preload(7'd1, 32'h214A000A);
    preload(7'd2, 32'h11111111);
    preload(7'd3, 32'h22222222);
    tick;
    total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL rst_if_ack got=%h exp=0", if_ack); end
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL rst_d_ack got=%h exp=0", d_ack); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    total++; if (mem_addr !== 7'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL rst_mem_wre got=%h exp=1", mem_wre); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_lone_fetch;
    tick;                                   // N
    if_req = 1'b1; if_addr = 7'd1;
    tick;                                   // N+1
    total++; if (mem_addr !== 7'd1) begin bad++; $display("FAIL fetch_addr got=%h exp=01", mem_addr); end
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL fetch_wre got=%h exp=1", mem_wre); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%h exp=1", busy); end
    total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%h exp=0", if_ack); end
    tick;                                   // N+2
    total++; if (if_ack !== 1'b1) begin bad++; $display("FAIL fetch_ack got=%h exp=1", if_ack); end
    total++; if (if_rdata !== 32'h214A000A) begin bad++; $display("FAIL fetch_rdata got=%h exp=214a000a", if_rdata); end
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL fetch_d_ack got=%h exp=0", d_ack); end
    tick;                                   // N+3
    if_req = 1'b0;
    total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack_pulse got=%h exp=0", if_ack); end
    tick;                                   // N+4
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_idle_busy got=%h exp=0", busy); end
  endtask

  task automatic test_store_load;
    tick;                                   // N
    d_req = 1'b1; d_we = 1'b1; d_addr = 7'h10; d_wdata = 32'hDEADBEEF;
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL st_wre_before got=%h exp=1", mem_wre); end
    tick;                                   // N+1
    total++; if (mem_wre !== 1'b0) begin bad++; $display("FAIL st_wre got=%h exp=0", mem_wre); end
    total++; if (mem_addr !== 7'h10) begin bad++; $display("FAIL st_addr got=%h exp=10", mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", mem_wdata); end
    tick;                                   // N+2
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL st_wre_after got=%h exp=1", mem_wre); end
    total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL st_ack got=%h exp=1", d_ack); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL st_rdata_kept got=%h exp=0", d_rdata); end
    total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL st_if_ack got=%h exp=0", if_ack); end
    tick;                                   // N+3
    d_req = 1'b0; d_we = 1'b0;
    tick;                                   // load cycle N
    d_req = 1'b1; d_addr = 7'h10;
    tick;
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL ld_wre got=%h exp=1", mem_wre); end
    tick;
    total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL ld_ack got=%h exp=1", d_ack); end
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", d_rdata); end
    tick;
    d_req = 1'b0;
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_simultaneous;
    logic [6:0]  exp_addr [4];
    logic        exp_isd  [4];
    logic [31:0] exp_data [4];
    exp_addr = '{7'd2, 7'd3, 7'd2, 7'd3};
    exp_isd  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222};
    do_reset;
    tick;                                   // N
    if_req = 1'b1; if_addr = 7'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 7'd3;
    for (int g = 0; g < 4; g++) begin
      tick;                                 // N+1+3g
      total++; if (mem_addr !== exp_addr[g]) begin bad++; $display("FAIL rr_addr%0d got=%h exp=%h", g, mem_addr, exp_addr[g]); end
      tick;                                 // N+2+3g
      total++; if (if_ack !== !exp_isd[g] || d_ack !== exp_isd[g]) begin bad++; $display("FAIL rr_ack%0d got=%b%b exp=%b%b", g, if_ack, d_ack, !exp_isd[g], exp_isd[g]); end
      total++; if ((exp_isd[g] ? d_rdata : if_rdata) !== exp_data[g]) begin bad++; $display("FAIL rr_rdata%0d got=%h exp=%h", g, exp_isd[g] ? d_rdata : if_rdata, exp_data[g]); end
      tick;                                 // N+3+3g
      total++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL rr_ack_pulse%0d got=%b%b exp=00", g, if_ack, d_ack); end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask
`else
  task automatic test_simultaneous;
    do_reset;
    tick;                                   // N
    if_req = 1'b1; if_addr = 7'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 7'd3;
    tick;                                   // N+1
    total++; if (mem_addr !== 7'd3) begin bad++; $display("FAIL fp_addr0 got=%h exp=03", mem_addr); end
    tick;                                   // N+2
    total++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin bad++; $display("FAIL fp_ack0 got=%b%b exp=01", if_ack, d_ack); end
    total++; if (d_rdata !== 32'h22222222) begin bad++; $display("FAIL fp_rdata0 got=%h exp=22222222", d_rdata); end
    tick;                                   // N+3
    d_req = 1'b0;
    tick;                                   // N+4
    total++; if (mem_addr !== 7'd2 || mem_wre !== 1'b1) begin bad++; $display("FAIL fp_addr1 got=%h/%b exp=02/1", mem_addr, mem_wre); end
    total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL fp_early_ack1 got=%h exp=0", if_ack); end
    tick;                                   // N+5
    total++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin bad++; $display("FAIL fp_ack1 got=%b%b exp=10", if_ack, d_ack); end
    total++; if (if_rdata !== 32'h11111111) begin bad++; $display("FAIL fp_rdata1 got=%h exp=11111111", if_rdata); end
    tick;                                   // N+6
    if_req = 1'b0;
  endtask
`endif

  task automatic test_reset_abort;
    tick;                                   // N
    d_req = 1'b1; d_we = 1'b1; d_addr = 7'h10; d_wdata = 32'hDEADBEEF;
    tick; tick; tick;
    d_req = 1'b0; d_we = 1'b0;
    tick;
    total++; if (d_rdata !== 32'h22222222) begin bad++; $display("FAIL ab_pre_rdata got=%h exp=22222222", d_rdata); end
    tick;                                   // N (load)
    d_req = 1'b1; d_addr = 7'h10;
    tick;                                   // N+1 ACCESS
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ab_busy_access got=%h exp=1", busy); end
    reset = 1'b1;
    tick;                                   // N+2
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL ab_no_ack got=%h exp=0", d_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%h exp=0", busy); end
    total++; if (mem_wre !== 1'b1) begin bad++; $display("FAIL ab_wre got=%h exp=1", mem_wre); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL ab_rdata got=%h exp=0", d_rdata); end
    tick;                                   // reset still high, req ignored
    total++; if (busy !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL ab_req_in_reset got=%b%b exp=00", busy, d_ack); end
    reset = 1'b0;                           // first cycle after reset: arbitrate
    tick;
    total++; if (busy !== 1'b1 || mem_addr !== 7'h10) begin bad++; $display("FAIL ab_restart got=%b/%h exp=1/10", busy, mem_addr); end
    tick;
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ab_restart_ack got=%b/%h exp=1/deadbeef", d_ack, d_rdata); end
    tick;
    d_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    tick;                                   // N
    d_req = 1'b1; d_we = 1'b0; d_addr = 7'd3;
    tick; tick;                             // N+2
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'h22222222) begin bad++; $display("FAIL b2b_ack0 got=%b/%h exp=1/22222222", d_ack, d_rdata); end
    tick;                                   // N+3, req still high
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%h exp=0", d_ack); end
    tick;                                   // N+4
    total++; if (busy !== 1'b1 || mem_addr !== 7'd3 || d_ack !== 1'b0) begin bad++; $display("FAIL b2b_access got=%b/%h/%b exp=1/03/0", busy, mem_addr, d_ack); end
    tick;                                   // N+5
    total++; if (d_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%h exp=1", d_ack); end
    tick;
    d_req = 1'b0;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%h exp=0", busy); end
  endtask

  initial begin
    test_reset;
    test_lone_fetch;
    test_store_load;
    test_simultaneous;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
